// File: rtl/sar_sequencer.sv
// rtl/sar_sequencer.sv - SAR conversion sequencer: strobe generation, MSB-first capture, valid/ready result port
module sar_sequencer #(
    parameter int Ndac          = 16,
    parameter int INIT_CYCLES   = 2,
    parameter int SETTLE_CYCLES = 1,
    parameter bit COMP_INV      = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            comp,
    output logic            clk_init,
    output logic            clk_update,
    output logic            clk_comp,
    output logic            busy,
    output logic [Ndac-1:0] result,
    output logic            result_valid,
    input  logic            result_ready,
    output logic            overrun
);

    localparam int BW   = $clog2(Ndac);
    localparam int CMAX = (INIT_CYCLES > SETTLE_CYCLES) ? INIT_CYCLES : SETTLE_CYCLES;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    localparam logic [CW-1:0] INIT_LAST   = CW'(INIT_CYCLES - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [BW-1:0] BIT_LAST    = BW'(Ndac - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_INIT   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_COMP   = 3'd3,
        ST_SAMPLE = 3'd4,
        ST_UPDATE = 3'd5,
        ST_DONE   = 3'd6
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [Ndac-1:0]   shift_q, shift_d;
    logic [Ndac-1:0]   result_q, result_d;
    logic              valid_q, valid_d;
    logic              overrun_q, overrun_d;
    logic              clk_init_q, clk_update_q, clk_comp_q, busy_q;

    // State, datapath and strobe registers; strobes are decoded from the next state so
    // each one is a flop that is high exactly while the FSM sits in the matching state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            result_q     <= '0;
            valid_q      <= 1'b0;
            overrun_q    <= 1'b0;
            clk_init_q   <= 1'b0;
            clk_update_q <= 1'b0;
            clk_comp_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            result_q     <= result_d;
            valid_q      <= valid_d;
            overrun_q    <= overrun_d;
            clk_init_q   <= (state_d == ST_INIT);
            clk_update_q <= (state_d == ST_UPDATE);
            clk_comp_q   <= (state_d == ST_COMP);
            busy_q       <= (state_d != ST_IDLE);
        end
    end

    // Next-state, counters, capture and result handshake.
    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        bit_d     = bit_q;
        shift_d   = shift_q;
        result_d  = result_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;

        // A consumer handshake drains the result unless DONE reloads it below.
        if (valid_q && result_ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_INIT;
                end
            end
            ST_INIT: begin
                shift_d = '0;
                bit_d   = '0;
                if (cnt_q == INIT_LAST) begin
                    state_d = ST_SETTLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_COMP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_COMP: begin
                state_d = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                // Shifting left places the first decision in the MSB after Ndac captures.
                shift_d = {shift_q[Ndac-2:0], comp ^ COMP_INV};
                state_d = ST_UPDATE;
            end
            ST_UPDATE: begin
                if (bit_q == BIT_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    bit_d   = bit_q + BW'(1);
                    state_d = ST_SETTLE;
                end
            end
            ST_DONE: begin
                result_d = shift_q;
                valid_d  = 1'b1;
                if (valid_q && !result_ready) begin
                    overrun_d = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign clk_init     = clk_init_q;
    assign clk_update   = clk_update_q;
    assign clk_comp     = clk_comp_q;
    assign busy         = busy_q;
    assign result       = result_q;
    assign result_valid = valid_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_sar_sequencer.sv
// tb/tb_sar_sequencer.sv - scoreboard testbench for sar_sequencer (Ndac=4)
module tb_sar_sequencer;

    localparam int N   = 4;
    localparam int IC  = 2;
    localparam int SC  = 1;
    localparam int LAT = IC + N * (SC + 3) + 2;

    typedef struct packed {
        logic [N-1:0] code;
        logic [31:0]  at;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] cyc = 32'd0;
    always @(posedge clk) cyc <= cyc + 32'd1;

    logic rst;
    logic start0, comp0, ready0, start1, comp1, ready1;
    logic init0, upd0, cmp0, busy0, vld0, ovr0;
    logic init1, upd1, cmp1, busy1, vld1, ovr1;
    logic [N-1:0] res0, res1;

    sar_sequencer #(.Ndac(N), .INIT_CYCLES(IC), .SETTLE_CYCLES(SC), .COMP_INV(1'b0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .comp(comp0),
        .clk_init(init0), .clk_update(upd0), .clk_comp(cmp0), .busy(busy0),
        .result(res0), .result_valid(vld0), .result_ready(ready0), .overrun(ovr0)
    );

    sar_sequencer #(.Ndac(N), .INIT_CYCLES(IC), .SETTLE_CYCLES(SC), .COMP_INV(1'b1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .comp(comp1),
        .clk_init(init1), .clk_update(upd1), .clk_comp(cmp1), .busy(busy1),
        .result(res1), .result_valid(vld1), .result_ready(ready1), .overrun(ovr1)
    );

    exp_t q0[$];
    exp_t q1[$];
    bit   comp_bits[$];
    exp_t e0, e1;
    int   n_chk = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Queue a dut0 conversion whose start is sampled at the next edge (plus off cycles).
    task automatic push0(input logic [N-1:0] code, input int off);
        exp_t e;
        e.code = code;
        e.at   = cyc + 32'(LAT + off);
        q0.push_back(e);
        for (int i = N - 1; i >= 0; i--) comp_bits.push_back(code[i]);
    endtask

    task automatic push1(input logic [N-1:0] code, input int off);
        exp_t e;
        e.code = code;
        e.at   = cyc + 32'(LAT + off);
        q1.push_back(e);
    endtask

    // Comparator model for dut0: present the next decision during the SAMPLE cycle.
    always @(negedge clk) begin
        if (cmp0) begin
            if (comp_bits.size() > 0) comp0 = comp_bits.pop_front();
            else comp0 = 1'b0;
        end
    end

    // Monitors: a fresh code is presented on the cycle busy drops with result_valid high.
    logic busy0_prev = 1'b0;
    logic busy1_prev = 1'b0;
    always @(negedge clk) begin
        if (busy0_prev && !busy0 && vld0) begin
            if (q0.size() == 0) begin
                chk("dut0_unexpected_result", 32'(res0), 32'hFFFF_FFFF);
            end else begin
                e0 = q0.pop_front();
                chk("dut0_code", 32'(res0), 32'(e0.code));
                chk("dut0_latency", cyc, e0.at);
            end
        end
        if (busy1_prev && !busy1 && vld1) begin
            if (q1.size() == 0) begin
                chk("dut1_unexpected_result", 32'(res1), 32'hFFFF_FFFF);
            end else begin
                e1 = q1.pop_front();
                chk("dut1_code", 32'(res1), 32'(e1.code));
                chk("dut1_latency", cyc, e1.at);
            end
        end
        busy0_prev = busy0;
        busy1_prev = busy1;
    end

    logic [31:0] base;
    logic        exp_init, exp_cmp, exp_upd, exp_busy, exp_vld;

    initial begin
        rst = 1'b1;
        start0 = 1'b0; comp0 = 1'b0; ready0 = 1'b0;
        start1 = 1'b0; comp1 = 1'b0; ready1 = 1'b0;
        tick(3);
        chk("reset_dut0_outputs", 32'({init0, upd0, cmp0, busy0, vld0, ovr0, res0}), 32'd0);
        chk("reset_dut1_outputs", 32'({init1, upd1, cmp1, busy1, vld1, ovr1, res1}), 32'd0);
        rst = 1'b0;
        tick(2);

        // Single conversion, comp = 1,0,1,1: strobe timeline per cycle.
        push0(4'hB, 0);
        base = cyc;
        start0 = 1'b1;
        tick(1);
        start0 = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            exp_init = (n == 1) || (n == 2);
            exp_cmp  = (n == 4) || (n == 8) || (n == 12) || (n == 16);
            exp_upd  = (n == 6) || (n == 10) || (n == 14) || (n == 18);
            exp_busy = (n <= 19);
            exp_vld  = (n == 20);
            chk($sformatf("trace_c%0d", n), 32'({init0, cmp0, upd0, busy0, vld0}),
                32'({exp_init, exp_cmp, exp_upd, exp_busy, exp_vld}));
            tick(1);
        end
        ready0 = 1'b1;
        tick(1);
        ready0 = 1'b0;
        chk("consume_valid", 32'(vld0), 32'd0);
        chk("consume_overrun", 32'(ovr0), 32'd0);

        // Two conversions without a consumer: second overwrites, overrun sticks.
        push0(4'hA, 0);
        start0 = 1'b1;
        tick(1);
        start0 = 1'b0;
        tick(21);
        chk("first_no_overrun", 32'(ovr0), 32'd0);
        push0(4'h5, 0);
        start0 = 1'b1;
        tick(1);
        start0 = 1'b0;
        tick(21);
        chk("overwrite_result", 32'(res0), 32'h5);
        chk("overwrite_valid", 32'(vld0), 32'd1);
        chk("overwrite_overrun", 32'(ovr0), 32'd1);
        ready0 = 1'b1;
        tick(1);
        ready0 = 1'b0;
        chk("drain_valid", 32'(vld0), 32'd0);
        chk("drain_overrun_sticky", 32'(ovr0), 32'd1);

        // Reset in cycle 9 of a conversion, restart at cycle 12.
        for (int i = 0; i < N; i++) comp_bits.push_back(1'b1);
        base = cyc;
        start0 = 1'b1;
        tick(1);
        start0 = 1'b0;
        tick(8);
        rst = 1'b1;
        comp_bits.delete();
        tick(1);
        rst = 1'b0;
        chk("midrst_outputs", 32'({init0, upd0, cmp0, busy0, vld0, ovr0, res0}), 32'd0);
        tick(2);
        chk("midrst_cycle", cyc - base, 32'd12);
        push0(4'hC, 0);
        start0 = 1'b1;
        tick(1);
        start0 = 1'b0;
        tick(21);

        // start held for 60 cycles: three full-length back-to-back conversions.
        ready0 = 1'b1;
        push0(4'h3, 0);
        push0(4'hC - 4'h3, 20);
        push0(4'h6, 40);
        start0 = 1'b1;
        tick(60);
        start0 = 1'b0;
        tick(3);
        chk("b2b_idle_after", 32'(busy0), 32'd0);
        ready0 = 1'b0;

        // COMP_INV=1 with comp=0; ready only in the second DONE cycle.
        comp1 = 1'b0;
        push1(4'hF, 0);
        push1(4'hF, 20);
        start1 = 1'b1;
        tick(21);
        start1 = 1'b0;
        tick(18);
        chk("inv_valid_held", 32'(vld1), 32'd1);
        chk("inv_done_busy", 32'(busy1), 32'd1);
        ready1 = 1'b1;
        tick(1);
        ready1 = 1'b0;
        chk("inv_reload_valid", 32'(vld1), 32'd1);
        chk("inv_reload_result", 32'(res1), 32'hF);
        chk("inv_no_overrun", 32'(ovr1), 32'd0);
        tick(1);
        chk("inv_valid_stays", 32'(vld1), 32'd1);
        ready1 = 1'b1;
        tick(1);
        ready1 = 1'b0;
        chk("inv_drain_valid", 32'(vld1), 32'd0);

        tick(5);
        chk("dut0_scoreboard_empty", 32'(q0.size()), 32'd0);
        chk("dut1_scoreboard_empty", 32'(q1.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
